// File: rtl/knn_feeder.sv
// KNN data-point feeder: streams N stored points plus a 3-cycle drain into the distance datapath.
// Optional cycle counter for the last run is built when KNN_FEEDER_PERF_EN is defined.
`ifndef WDATA_W
`define WDATA_W 32
`endif
`ifndef K_NUM_DATA_PTS
`define K_NUM_DATA_PTS 100
`endif
`ifndef K_NUM_DATA_PTS_BIT
`define K_NUM_DATA_PTS_BIT 7
`endif

module knn_feeder (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           abort,
  input  logic [`WDATA_W-1:0]            test_pt,
  input  logic [`K_NUM_DATA_PTS_BIT-1:0] num_pts,
  output logic                           mem_en,
  output logic [`K_NUM_DATA_PTS_BIT-1:0] mem_addr,
  input  logic [`WDATA_W-1:0]            mem_rdata,
  output logic [`WDATA_W-1:0]            knn_test_pt_dp,
  output logic [`WDATA_W-1:0]            knn_data_pt_dp,
  output logic                           knn_start_dp,
  output logic                           knn_sample_dp,
  output logic                           busy,
  output logic                           done,
  output logic                           err,
  output logic [15:0]                    perf_cycles
);

  localparam int AW = `K_NUM_DATA_PTS_BIT;
  localparam int DW = `WDATA_W;
  localparam int unsigned MAX_PTS = `K_NUM_DATA_PTS;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREFETCH = 3'd1,
    ST_STREAM   = 3'd2,
    ST_SAMPLE   = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  state_t          state_r;
  logic [DW-1:0]   test_pt_r;
  logic [AW-1:0]   n_r;
  logic [7:0]      cnt_r;
  logic            mem_en_r;
  logic [AW-1:0]   mem_addr_r;
  logic            start_dp_r;
  logic            sample_r;
  logic            data_sel_r;
  logic            busy_r;
  logic            done_r;
  logic            err_r;
  logic            valid_s;
  logic [7:0]      n_ext_s;

  assign valid_s = (num_pts != {AW{1'b0}}) && (32'(num_pts) <= MAX_PTS);
  assign n_ext_s = 8'(n_r);

  // Run sequencer; the stream counter c indexes the N data cycles plus the 3 drain cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      test_pt_r  <= {DW{1'b0}};
      n_r        <= {AW{1'b0}};
      cnt_r      <= 8'd0;
      mem_en_r   <= 1'b0;
      mem_addr_r <= {AW{1'b0}};
      start_dp_r <= 1'b0;
      sample_r   <= 1'b0;
      data_sel_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      err_r    <= 1'b0;
      done_r   <= 1'b0;
      sample_r <= 1'b0;
      if ((state_r != ST_IDLE) && abort) begin
        state_r    <= ST_IDLE;
        busy_r     <= 1'b0;
        mem_en_r   <= 1'b0;
        start_dp_r <= 1'b0;
        data_sel_r <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (start) begin
              if (valid_s) begin
                test_pt_r  <= test_pt;
                n_r        <= num_pts;
                state_r    <= ST_PREFETCH;
                busy_r     <= 1'b1;
                mem_en_r   <= 1'b1;
                mem_addr_r <= {AW{1'b0}};
              end else begin
                err_r <= 1'b1;
              end
            end
          end
          ST_PREFETCH: begin
            state_r    <= ST_STREAM;
            cnt_r      <= 8'd0;
            start_dp_r <= 1'b1;
            data_sel_r <= 1'b1;
            mem_en_r   <= (n_ext_s > 8'd1);
            if (n_ext_s > 8'd1) begin
              mem_addr_r <= AW'(1);
            end
          end
          ST_STREAM: begin
            if (cnt_r == (n_ext_s + 8'd2)) begin
              state_r    <= ST_SAMPLE;
              start_dp_r <= 1'b0;
              data_sel_r <= 1'b0;
              mem_en_r   <= 1'b0;
              sample_r   <= 1'b1;
            end else begin
              // Outputs are registered, so look one cycle ahead: next c is cnt_r+1.
              cnt_r      <= cnt_r + 8'd1;
              data_sel_r <= ((cnt_r + 8'd1) < n_ext_s);
              mem_en_r   <= ((cnt_r + 8'd2) < n_ext_s);
              if ((cnt_r + 8'd2) < n_ext_s) begin
                mem_addr_r <= AW'(cnt_r + 8'd2);
              end
            end
          end
          ST_SAMPLE: begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
          end
          ST_DONE: begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
          default: begin
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
            mem_en_r   <= 1'b0;
            start_dp_r <= 1'b0;
            data_sel_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign mem_en         = mem_en_r;
  assign mem_addr       = mem_addr_r;
  assign knn_test_pt_dp = test_pt_r;
  assign knn_data_pt_dp = data_sel_r ? mem_rdata : {DW{1'b0}};
  assign knn_start_dp   = start_dp_r;
  assign knn_sample_dp  = sample_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign err            = err_r;

`ifdef KNN_FEEDER_PERF_EN
  logic [15:0] perf_cnt_r;
  logic [15:0] perf_cycles_r;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

  // Run-length counter; the DONE cycle itself is included in the loaded value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cnt_r    <= 16'd0;
      perf_cycles_r <= 16'd0;
    end else if (state_r == ST_IDLE) begin
      if (start && valid_s) begin
        perf_cnt_r <= 16'd0;
      end
    end else begin
      perf_cnt_r <= sat_inc(perf_cnt_r);
      if ((state_r == ST_DONE) && !abort) begin
        perf_cycles_r <= sat_inc(perf_cnt_r);
      end
    end
  end

  assign perf_cycles = perf_cycles_r;
`else
  assign perf_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_knn_feeder.sv
// Self-checking bench for knn_feeder: vector table of runs, data-stream scoreboard, reset corner case.
module tb_knn_feeder;

`ifdef K_NUM_DATA_PTS
  localparam int KMAX = `K_NUM_DATA_PTS;
`else
  localparam int KMAX = 100;
`endif

  logic        clk = 1'b0;
  logic        rst_n, start, abort;
  logic [31:0] test_pt;
  logic [6:0]  num_pts;
  logic        mem_en;
  logic [6:0]  mem_addr;
  logic [31:0] mem_rdata;
  logic [31:0] knn_test_pt_dp, knn_data_pt_dp;
  logic        knn_start_dp, knn_sample_dp, busy, done, err;
  logic [15:0] perf_cycles;

  logic [31:0] mem [0:127];
  logic [31:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_perf = 16'd0;
  logic [31:0] last_tp  = 32'd0;

  knn_feeder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .test_pt(test_pt), .num_pts(num_pts),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .knn_test_pt_dp(knn_test_pt_dp), .knn_data_pt_dp(knn_data_pt_dp),
    .knn_start_dp(knn_start_dp), .knn_sample_dp(knn_sample_dp),
    .busy(busy), .done(done), .err(err), .perf_cycles(perf_cycles)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  typedef struct {
    logic [6:0]  n;
    logic [31:0] tp;
    bit          exp_err;
    int          abort_c;
    bit          repulse;
    bit          abort_start;
  } vec_t;

  task automatic do_run(input vec_t v);
    int start_cnt = 0, samp_cnt = 0, done_cyc = 0, err_cnt = 0, rd_cnt = 0;
    bit rd_ok = 1'b1, finished = 1'b0, aborted = 1'b0, repulsed = 1'b0;
    int exp_start, exp_rd;
    logic [31:0] got;
    @(negedge clk);
    start = 1'b1; num_pts = v.n; test_pt = v.tp; abort = v.abort_start;
    exp_q.delete();
    if (!v.exp_err)
      for (int c = 0; c < int'(v.n) + 3; c++) exp_q.push_back(c < int'(v.n) ? mem[c] : 32'd0);
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin start = 1'b0; abort = 1'b0; end
      if (aborted) abort = 1'b0;
      if (repulsed) start = 1'b0;
      if (err) err_cnt++;
      if (knn_sample_dp) samp_cnt++;
      if (done) done_cyc = cyc;
      if (mem_en) begin
        if (mem_addr != 7'(rd_cnt)) rd_ok = 1'b0;
        rd_cnt++;
      end
      if (knn_start_dp) begin
        start_cnt++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_underflow: got %0h expected none", knn_data_pt_dp);
        end else begin
          got = exp_q.pop_front();
          chk("stream_data", knn_data_pt_dp, got);
        end
        if (v.abort_c >= 0 && !aborted && start_cnt == v.abort_c + 1) begin
          abort = 1'b1; aborted = 1'b1;
        end
        if (v.repulse && !repulsed && start_cnt == 3) begin
          start = 1'b1; test_pt = ~v.tp; repulsed = 1'b1;
        end
      end
      if (cyc >= 2 && !busy) begin finished = 1'b1; break; end
    end
    chk("run_terminated", 32'(finished), 32'd1);
    if (!v.exp_err && !aborted) begin
      exp_start = int'(v.n) + 3;
      exp_rd    = int'(v.n);
`ifdef KNN_FEEDER_PERF_EN
      exp_perf  = 16'(int'(v.n) + 6);
`endif
      last_tp   = v.tp;
      chk("sb_empty", 32'(exp_q.size()), 32'd0);
    end else if (aborted) begin
      exp_start = v.abort_c + 1;
      exp_rd    = 1 + ((v.abort_c + 1 < int'(v.n) - 1) ? v.abort_c + 1 : int'(v.n) - 1);
      last_tp   = v.tp;
    end else begin
      exp_start = 0;
      exp_rd    = 0;
    end
    chk("err_pulses", 32'(err_cnt), v.exp_err ? 32'd1 : 32'd0);
    chk("start_dp_cycles", 32'(start_cnt), 32'(exp_start));
    chk("sample_pulses", 32'(samp_cnt), (v.exp_err || aborted) ? 32'd0 : 32'd1);
    chk("done_latency", 32'(done_cyc), (v.exp_err || aborted) ? 32'd0 : 32'(int'(v.n) + 6));
    chk("mem_reads", 32'(rd_cnt), 32'(exp_rd));
    chk("mem_addr_order", 32'(rd_ok), 32'd1);
    chk("test_pt_hold", knn_test_pt_dp, last_tp);
    chk("perf_cycles", 32'(perf_cycles), 32'(exp_perf));
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  vec_t vecs[10];

  initial begin
    for (int k = 0; k < 128; k++) mem[k] = {16'(k), 16'(k)};
    vecs[0] = '{7'd8,           32'h0003_0003, 1'b0, -1, 1'b0, 1'b0};
    vecs[1] = '{7'd1,           32'h0001_0002, 1'b0, -1, 1'b0, 1'b0};
    vecs[2] = '{7'd0,           32'hDEAD_BEEF, 1'b1, -1, 1'b0, 1'b0};
    vecs[3] = '{7'(KMAX + 1),   32'hCAFE_F00D, 1'b1, -1, 1'b0, 1'b0};
    vecs[4] = '{7'd8,           32'h0010_0020, 1'b0,  5, 1'b0, 1'b0};
    vecs[5] = '{7'd8,           32'h0004_0005, 1'b0, -1, 1'b0, 1'b0};
    vecs[6] = '{7'd5,           32'h0007_0001, 1'b0, -1, 1'b1, 1'b0};
    vecs[7] = '{7'd3,           32'h0002_0009, 1'b0, -1, 1'b0, 1'b1};
    vecs[8] = '{7'(KMAX),       32'h0050_0050, 1'b0, -1, 1'b0, 1'b0};
    vecs[9] = '{7'd2,           32'h00AA_0055, 1'b0, -1, 1'b0, 1'b0};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; test_pt = 32'd0; num_pts = 7'd0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_ctrl", {26'd0, mem_en, knn_start_dp, knn_sample_dp, done, err, 1'b0}, 32'd0);
    chk("reset_test_pt", knn_test_pt_dp, 32'd0);
    chk("reset_perf", 32'(perf_cycles), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) do_run(vecs[i]);

    // Reset asserted in the middle of a stream.
    @(negedge clk); start = 1'b1; num_pts = 7'd8; test_pt = 32'h0011_0022;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_reset_stream", 32'(knn_start_dp), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrun_reset_ctrl", {25'd0, busy, mem_en, knn_start_dp, knn_sample_dp, done, err, 1'b0}, 32'd0);
    chk("midrun_reset_addr", 32'(mem_addr), 32'd0);
    chk("midrun_reset_data", knn_data_pt_dp, 32'd0);
    chk("midrun_reset_test_pt", knn_test_pt_dp, 32'd0);
    chk("midrun_reset_perf", 32'(perf_cycles), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_reset_idle", {30'd0, busy, knn_start_dp}, 32'd0);
    exp_perf = 16'd0; last_tp = 32'd0;
    do_run(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
